// File: rtl/word_serializer.sv
// word_serializer: parallel words in over valid/ready, MSB-first serial bits out with sof/eof framing.
// Optional macro SER_REF_MOD3_EN builds a reference mod-3 residue that drives ref_div3 on eof.
module word_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy,
    output logic             ref_div3
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] pend_data;
    logic             pend_valid;
    logic [WIDTH-1:0] sh_reg;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             load;
    logic             accept;

    assign last_bit = (cnt == LAST);
    assign accept   = in_valid && in_ready;
    // A pending word loads on the edge ending the current eof cycle, giving gap-free streams.
    assign load     = pend_valid && ((state == IDLE) || ((state == SHIFT) && last_bit));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (!load && last_bit) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_data  <= '0;
            pend_valid <= 1'b0;
            sh_reg     <= '0;
            cnt        <= '0;
        end else begin
            if (accept) begin
                pend_data  <= in_data;
                pend_valid <= 1'b1;
            end else if (load) begin
                pend_valid <= 1'b0;
            end

            if (load) begin
                sh_reg <= pend_data;
                cnt    <= '0;
            end else if ((state == SHIFT) && !last_bit) begin
                sh_reg <= {sh_reg[WIDTH-2:0], 1'b0};
                cnt    <= cnt + CW'(1);
            end
        end
    end

    assign in_ready  = !pend_valid;
    assign bit_valid = (state == SHIFT);
    assign bit_out   = bit_valid & sh_reg[WIDTH-1];
    assign sof       = bit_valid & (cnt == '0);
    assign eof       = bit_valid & last_bit;
    assign busy      = bit_valid | pend_valid;

`ifdef SER_REF_MOD3_EN
    logic [1:0] res;
    logic [1:0] res_nx;
    logic [2:0] res_sum;

    // Residue of the bits emitted so far, folded with the bit on the line this cycle.
    always_comb begin
        res_sum = {res, bit_out};
        res_nx  = (res_sum >= 3'd3) ? 2'(res_sum - 3'd3) : res_sum[1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res <= 2'd0;
        end else if (load) begin
            res <= 2'd0;
        end else if (state == SHIFT) begin
            res <= res_nx;
        end
    end

    assign ref_div3 = eof & (res_nx == 2'd0);
`else
    assign ref_div3 = 1'b0;
`endif

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: directed word table, hand-written corner sequences,
// and randomized traffic checked by a queue-based word model running on every falling edge.
module tb_word_serializer;
    localparam int WIDTH = 8;

`ifdef SER_REF_MOD3_EN
    localparam bit MOD3_EN = 1'b1;
`else
    localparam bit MOD3_EN = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] word;
        logic             div3;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             sof;
    logic             eof;
    logic             busy;
    logic             ref_div3;

    int n_checks = 0;
    int n_fail   = 0;

    word_serializer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bit_out  (bit_out),
        .bit_valid(bit_valid),
        .sof      (sof),
        .eof      (eof),
        .busy     (busy),
        .ref_div3 (ref_div3)
    );

    always #5 clk = ~clk;

    function automatic logic exp_div3(input logic [WIDTH-1:0] w);
        return MOD3_EN && ((w % 3) == 0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Word-level model: accepted words queue up and must reappear intact, in order, once each.
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] cur = '0;
    logic [WIDTH-1:0] exp_w;
    logic             mon_en = 1'b0;
    int               nbits = 0;
    int               words_done = 0;
    bit               ready_low_seen = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst) begin
                exp_q.delete();
                nbits = 0;
                cur   = '0;
            end else begin
                checkOutput("busy_decode", busy, bit_valid || !in_ready);
                if (!in_ready) ready_low_seen = 1'b1;
                if (in_valid && in_ready) exp_q.push_back(in_data);
                if (bit_valid) begin
                    checkOutput("sof_frame", sof, nbits == 0);
                    cur = {cur[WIDTH-2:0], bit_out};
                    nbits++;
                    checkOutput("eof_frame", eof, nbits == WIDTH);
                    if (nbits == WIDTH) begin
                        checkOutput("word_present", exp_q.size() > 0, 1'b1);
                        if (exp_q.size() > 0) begin
                            exp_w = exp_q.pop_front();
                            checkOutput("word_data", cur, exp_w);
                            checkOutput("ref_div3_eof", ref_div3, exp_div3(exp_w));
                        end
                        words_done++;
                        nbits = 0;
                    end else begin
                        checkOutput("ref_div3_mid", ref_div3, 1'b0);
                    end
                end else begin
                    checkOutput("idle_outputs", {bit_out, sof, eof, ref_div3}, 4'b0000);
                    checkOutput("gap_mid_word", nbits, 0);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] w);
        bit done;
        done = 1'b0;
        @(posedge clk);
        #1;
        in_data  = w;
        in_valid = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        checkOutput("accept_timeout", done, 1'b1);
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 200 && !idle; k++) begin
            @(negedge clk);
            idle = !busy;
        end
        checkOutput("idle_timeout", idle, 1'b1);
    endtask

    // Single word from idle: exact latency, bit order and framing cycle by cycle.
    task automatic runDirected(input logic [WIDTH-1:0] w, input logic div3, input string tag);
        applyStimulus(w);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_pre_valid"}, bit_valid, 1'b0);
        checkOutput({tag, "_pre_ready"}, in_ready, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            checkOutput({tag, "_valid"}, bit_valid, 1'b1);
            checkOutput({tag, "_bit"}, bit_out, w[WIDTH-1-i]);
            checkOutput({tag, "_sof"}, sof, i == 0);
            checkOutput({tag, "_eof"}, eof, i == WIDTH - 1);
            checkOutput({tag, "_ref_div3"}, ref_div3, (i == WIDTH - 1) ? (MOD3_EN & div3) : 1'b0);
            if (i == 0) checkOutput({tag, "_ready_back"}, in_ready, 1'b1);
        end
        @(negedge clk);
        checkOutput({tag, "_post_valid"}, bit_valid, 1'b0);
        checkOutput({tag, "_post_busy"}, busy, 1'b0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 1'b1);
        checkOutput({tag, "_bit_out"}, bit_out, 1'b0);
        checkOutput({tag, "_bit_valid"}, bit_valid, 1'b0);
        checkOutput({tag, "_sof"}, sof, 1'b0);
        checkOutput({tag, "_eof"}, eof, 1'b0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_ref_div3"}, ref_div3, 1'b0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        int   run;
        int   sof_at;
        bit   seen;
        bit   found;
        int   base;

        vecs[0] = '{8'h06, 1'b1};
        vecs[1] = '{8'h00, 1'b1};
        vecs[2] = '{8'h07, 1'b0};
        vecs[3] = '{8'h09, 1'b1};
        vecs[4] = '{8'hFF, 1'b1};
        vecs[5] = '{8'h01, 1'b0};
        vecs[6] = '{8'hA5, 1'b1};
        vecs[7] = '{8'h80, 1'b0};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Asynchronous reset asserted between edges must clear outputs without a clock.
        #12;
        rst    = 1'b0;
        mon_en = 1'b1;
        #1;
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            runDirected(vecs[i].word, vecs[i].div3, $sformatf("vec%0d", i));
        end

        // Back-to-back words with in_valid held: one contiguous 16-bit run, second sof right after eof.
        run    = 0;
        sof_at = -1;
        seen   = 1'b0;
        fork
            begin
                applyStimulus(8'hFF);
                applyStimulus(8'h01);
                checkOutput("b2b_ready_low", in_ready, 1'b0);
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (bit_valid) begin
                        if (sof && run > 0) sof_at = run;
                        run++;
                        seen = 1'b1;
                    end else if (seen) begin
                        break;
                    end
                end
                checkOutput("b2b_run_len", run, 16);
                checkOutput("b2b_second_sof", sof_at, 8);
            end
        join
        waitIdle();

        // Backpressure: three words offered back to back.
        base           = words_done;
        ready_low_seen = 1'b0;
        applyStimulus(8'h3C);
        applyStimulus(8'hC3);
        applyStimulus(8'h5A);
        in_valid = 1'b0;
        waitIdle();
        checkOutput("bp_ready_dropped", ready_low_seen, 1'b1);
        checkOutput("bp_words_done", words_done - base, 3);
        checkOutput("bp_queue_empty", exp_q.size(), 0);

        // Reset after the 4th bit of a word discards it; the next word starts cleanly.
        applyStimulus(8'hA5);
        in_valid = 1'b0;
        found    = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = bit_valid && sof;
        end
        checkOutput("midrst_sof_seen", found, 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkResetOutputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        runDirected(8'h03, 1'b1, "after_rst");

        // Randomized traffic with random idle gaps.
        base = words_done;
        for (int n = 0; n < 40; n++) begin
            applyStimulus(WIDTH'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = WIDTH'($urandom);
                repeat ($urandom_range(1, 12)) @(posedge clk);
            end
        end
        in_valid = 1'b0;
        waitIdle();
        checkOutput("rand_words_done", words_done - base, 40);
        checkOutput("rand_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
